// File: rtl/csr_exec_unit.sv
// csr_exec_unit: executes one Zicsr request per transaction against the machine-mode CSR subset.
// Define CSR_USER_COUNTERS_EN to expose read-only user counters at 0xC00-0xC02 / 0xC80-0xC82.
module csr_exec_unit #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [16:0] req_params,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_imm,
  input  logic [4:0]  req_rd,
  input  logic [1:0]  req_priv,
  input  logic        retire,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_illegal
);
  localparam logic [1:0] CSR_WRITE_NONE = 2'b00;
  localparam logic [1:0] CSR_WRITE_RW   = 2'b01;
  localparam logic [1:0] CSR_WRITE_RS   = 2'b10;
  localparam logic [1:0] CSR_WRITE_RC   = 2'b11;
  localparam logic       CSR_SEL_IMM    = 1'b1;
  localparam logic [1:0] CSR_ADDR_RO    = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
  state_e state_q, state_d;

  logic        req_ready_q, accept;
  logic [15:0] params_q;
  logic [31:0] rs1_q;
  logic [4:0]  imm_q, rd_q;
  logic [1:0]  priv_q;

  // Reads return the old value regardless of read_enable, so the bit is not needed.
  logic unused_read_enable;
  assign unused_read_enable = req_params[16];

  logic [11:0] addr;
  logic [1:0]  write_func;
  logic        input_select, write_enable;
  assign addr         = params_q[11:0];
  assign write_func   = params_q[13:12];
  assign input_select = params_q[14];
  assign write_enable = params_q[15];

  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [2:0]  mie_q;
  logic [29:0] mtvec_q, mepc_q;
  logic [31:0] mscratch_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [31:0] resp_rdata_q;
  logic [4:0]  resp_rd_q;
  logic        resp_illegal_q;

  logic [31:0] old_val, src, new_val;
  logic        implemented, write_req, legal, do_write;

  assign accept     = req_valid & req_ready_q;
  assign req_ready  = req_ready_q;
  assign resp_valid = (state_q == StResp);
  assign resp_rdata   = resp_rdata_q;
  assign resp_rd      = resp_rd_q;
  assign resp_illegal = resp_illegal_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == StIdle);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      params_q <= '0;
      rs1_q    <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      priv_q   <= '0;
    end else if (accept) begin
      params_q <= req_params[15:0];
      rs1_q    <= req_rs1_val;
      imm_q    <= req_imm;
      rd_q     <= req_rd;
      priv_q   <= req_priv;
    end
  end

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (addr)
      12'h300: old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      12'h301: old_val = 32'h4000_0100;
      12'h304: old_val = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
      12'h305: old_val = {mtvec_q, 2'b00};
      12'h340: old_val = mscratch_q;
      12'h341: old_val = {mepc_q, 2'b00};
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
      12'h344: old_val = '0;
      12'hB00: old_val = mcycle_q[31:0];
      12'hB80: old_val = mcycle_q[63:32];
      12'hB02: old_val = minstret_q[31:0];
      12'hB82: old_val = minstret_q[63:32];
      12'hF11, 12'hF12, 12'hF13: old_val = '0;
      12'hF14: old_val = HART_ID;
`ifdef CSR_USER_COUNTERS_EN
      12'hC00, 12'hC01: old_val = mcycle_q[31:0];
      12'hC80, 12'hC81: old_val = mcycle_q[63:32];
      12'hC02: old_val = minstret_q[31:0];
      12'hC82: old_val = minstret_q[63:32];
`endif
      default: implemented = 1'b0;
    endcase
  end

  assign write_req = write_enable & (write_func != CSR_WRITE_NONE);
  assign legal     = implemented & (priv_q >= addr[9:8])
                   & ~(write_req & (addr[11:10] == CSR_ADDR_RO));
  assign src       = (input_select == CSR_SEL_IMM) ? {27'b0, imm_q} : rs1_q;
  assign do_write  = (state_q == StExec) & legal & write_req;

  always_comb begin
    new_val = old_val;
    case (write_func)
      CSR_WRITE_RW: new_val = src;
      CSR_WRITE_RS: new_val = old_val | src;
      CSR_WRITE_RC: new_val = old_val & ~src;
      default:      new_val = old_val;
    endcase
  end

  // WARL masking happens here; misa and mip silently drop writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC[31:2];
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else if (do_write) begin
      case (addr)
        12'h300: begin
          mstatus_mie_q  <= new_val[3];
          mstatus_mpie_q <= new_val[7];
        end
        12'h304: mie_q      <= {new_val[11], new_val[7], new_val[3]};
        12'h305: mtvec_q    <= new_val[31:2];
        12'h340: mscratch_q <= new_val;
        12'h341: mepc_q     <= new_val[31:2];
        12'h342: mcause_q   <= new_val;
        12'h343: mtval_q    <= new_val;
        default: ;
      endcase
    end
  end

  // A CSR write to a counter half suppresses that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q <= '0;
    end else if (do_write && addr == 12'hB00) begin
      mcycle_q[31:0] <= new_val;
    end else if (do_write && addr == 12'hB80) begin
      mcycle_q[63:32] <= new_val;
    end else begin
      mcycle_q <= mcycle_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minstret_q <= '0;
    end else if (do_write && addr == 12'hB02) begin
      minstret_q[31:0] <= new_val;
    end else if (do_write && addr == 12'hB82) begin
      minstret_q[63:32] <= new_val;
    end else if (retire) begin
      minstret_q <= minstret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_q   <= '0;
      resp_rd_q      <= '0;
      resp_illegal_q <= 1'b0;
    end else if (state_q == StExec) begin
      resp_rdata_q   <= legal ? old_val : 32'd0;
      resp_rd_q      <= rd_q;
      resp_illegal_q <= ~legal;
    end
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Self-checking bench for csr_exec_unit: directed scenarios plus randomized requests
// checked against a behavioural CSR model with cycle-indexed counter arithmetic.
module tb_csr_exec_unit;
  localparam logic [1:0] F_NONE = 2'd0, F_RW = 2'd1, F_RS = 2'd2, F_RC = 2'd3;
  localparam logic [1:0] P_U = 2'd0, P_M = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [16:0] req_params = '0;
  logic [31:0] req_rs1_val = '0;
  logic [4:0]  req_imm = '0;
  logic [4:0]  req_rd = '0;
  logic [1:0]  req_priv = '0;
  logic        retire = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_illegal;

  csr_exec_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_params  (req_params),
    .req_rs1_val (req_rs1_val),
    .req_imm     (req_imm),
    .req_rd      (req_rd),
    .req_priv    (req_priv),
    .retire      (retire),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_rd     (resp_rd),
    .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference CSR state
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] mc_base, m_mi;
  longint      mc_edge;

  task automatic model_reset(input longint r);
    m_mstatus = 32'h0000_1800; m_mie = 0; m_mtvec = 32'h0000_0100;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    mc_base = 0; mc_edge = r; m_mi = 0;
  endtask

  // mcycle value held after posedge number k
  function automatic logic [63:0] mc_at(input longint k);
    return mc_base + 64'(k - mc_edge);
  endfunction

  function automatic logic model_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
`ifdef CSR_USER_COUNTERS_EN
      12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a, input longint k);
    logic [63:0] c;
    c = mc_at(k);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00, 12'hC00, 12'hC01: return c[31:0];
      12'hB80, 12'hC80, 12'hC81: return c[63:32];
      12'hB02, 12'hC02: return m_mi[31:0];
      12'hB82, 12'hC82: return m_mi[63:32];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] v, input longint e);
    logic [63:0] t;
    t = mc_at(e - 1);
    case (a)
      12'h300: m_mstatus = 32'h0000_1800 | (v & 32'h0000_0088);
      12'h304: m_mie = v & 32'h0000_0888;
      12'h305: m_mtvec = v & 32'hFFFF_FFFC;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & 32'hFFFF_FFFC;
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      12'hB00: begin t[31:0] = v; mc_base = t; mc_edge = e; end
      12'hB80: begin t[63:32] = v; mc_base = t; mc_edge = e; end
      12'hB02: m_mi[31:0] = v;
      12'hB82: m_mi[63:32] = v;
      default: ;
    endcase
  endtask

  // One request/response; called and returning at a negedge.
  task automatic run_op(input string tag, input logic [11:0] a, input logic we, input logic sel,
                        input logic [1:0] func, input logic [31:0] rs1, input logic [4:0] imm,
                        input logic [1:0] priv, input int hold,
                        output logic [31:0] rdata_seen, output logic ill_seen);
    logic [31:0] exp_old, src, nv;
    logic        wreq, legal;
    logic [4:0]  rd;
    longint      acc;
    int          n;
    rdata_seen = 'x;
    ill_seen = 'x;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin check_eq({tag, "/ready_timeout"}, 32'(req_ready), 32'd1); return; end
    rd = 5'($urandom);
    req_valid = 1'b1;
    req_params = {1'b1, we, sel, func, a};
    req_rs1_val = rs1; req_imm = imm; req_rd = rd; req_priv = priv;
    resp_ready = (hold == 0);
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    wreq = we && (func != F_NONE);
    legal = model_impl(a) && (priv >= a[9:8]) && !(wreq && a[11:10] == 2'b11);
    exp_old = legal ? model_read(a, acc) : 32'd0;
    if (legal && wreq) begin
      src = sel ? {27'b0, imm} : rs1;
      case (func)
        F_RW:    nv = src;
        F_RS:    nv = exp_old | src;
        default: nv = exp_old & ~src;
      endcase
      model_write(a, nv, acc + 1);
    end
    @(negedge clk);
    check_eq({tag, "/latency"}, 32'(resp_valid), 32'd1);
    n = 0;
    while (!resp_valid && n < 10) begin @(negedge clk); n++; end
    rdata_seen = resp_rdata;
    ill_seen = resp_illegal;
    check_eq({tag, "/rdata"}, resp_rdata, exp_old);
    check_eq({tag, "/illegal"}, 32'(resp_illegal), 32'(!legal));
    check_eq({tag, "/rd"}, 32'(resp_rd), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
      check_eq({tag, "/hold_rdata"}, resp_rdata, exp_old);
      check_eq({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "/done_valid"}, 32'(resp_valid), 32'd0);
  endtask

  logic [11:0] addr_pool [24] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                  12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hC00,
                                  12'hC01, 12'hC82, 12'h7C0, 12'h3A0, 12'h306, 12'h000};

  initial begin
    logic [31:0] r;
    logic        il;
    model_reset(0);
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_rd", 32'(resp_rd), 32'd0);
    check_eq("rst_illegal", 32'(resp_illegal), 32'd0);
    rst_n = 1'b1;
    model_reset(cyc);
    check_eq("rel_req_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("rel_req_ready_high", 32'(req_ready), 32'd1);

    run_op("t1_rw", 12'h340, 1, 0, F_RW, 32'hDEAD_BEEF, 0, P_M, 0, r, il);
    check_eq("t1_old", r, 32'd0);
    run_op("t1_rd", 12'h340, 0, 0, F_RS, 0, 0, P_M, 0, r, il);
    check_eq("t1_read", r, 32'hDEAD_BEEF);

    run_op("t2_set", 12'h340, 1, 0, F_RW, 32'hFF00_00FF, 0, P_M, 0, r, il);
    run_op("t2_rc", 12'h340, 1, 1, F_RC, 32'hFFFF_FFFF, 5'h0F, P_M, 0, r, il);
    check_eq("t2_old", r, 32'hFF00_00FF);
    run_op("t2_rd", 12'h340, 0, 0, F_RS, 0, 0, P_M, 0, r, il);
    check_eq("t2_read", r, 32'hFF00_00F0);

    run_op("t3_rw", 12'h300, 1, 0, F_RW, 32'hFFFF_FFFF, 0, P_M, 0, r, il);
    run_op("t3_rd", 12'h300, 0, 0, F_RS, 0, 0, P_M, 0, r, il);
    check_eq("t3_mstatus", r, 32'h0000_1888);

    run_op("t4_hartid", 12'hF14, 1, 0, F_RW, 32'h1234_5678, 0, P_M, 0, r, il);
    check_eq("t4_hartid_ill", 32'(il), 32'd1);
    check_eq("t4_hartid_rdata", r, 32'd0);
    run_op("t4_upriv", 12'h340, 1, 0, F_RS, 32'h1, 0, P_U, 0, r, il);
    check_eq("t4_upriv_ill", 32'(il), 32'd1);

    run_op("t5_mcyh", 12'hB80, 1, 0, F_RW, 32'd0, 0, P_M, 0, r, il);
    run_op("t5_mcyl", 12'hB00, 1, 0, F_RW, 32'hFFFF_FFFF, 0, P_M, 0, r, il);
    run_op("t5_rdh", 12'hB80, 0, 0, F_RS, 0, 0, P_M, 0, r, il);
    check_eq("t5_mcycleh", r, 32'd1);
    run_op("t5_mil", 12'hB02, 1, 0, F_RW, 32'hFFFF_FFFE, 0, P_M, 0, r, il);
    run_op("t5_mih", 12'hB82, 1, 0, F_RW, 32'd0, 0, P_M, 0, r, il);
    retire = 1'b1;
    repeat (3) @(negedge clk);
    retire = 1'b0;
    m_mi = m_mi + 64'd3;
    run_op("t5_rdil", 12'hB02, 0, 0, F_RS, 0, 0, P_M, 0, r, il);
    check_eq("t5_minstret", r, 32'd1);
    run_op("t5_rdih", 12'hB82, 0, 0, F_RS, 0, 0, P_M, 0, r, il);
    check_eq("t5_minstreth", r, 32'd1);

    run_op("t6_hold", 12'h340, 0, 0, F_RS, 0, 0, P_M, 4, r, il);

    // Reset while the request sits in EXEC: the write must be lost.
    req_valid = 1'b1;
    req_params = {1'b1, 1'b1, 1'b0, F_RW, 12'h340};
    req_rs1_val = 32'h1234_5678;
    req_priv = P_M;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    check_eq("t6_rst_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check_eq("t6_rst_valid2", 32'(resp_valid), 32'd0);
    check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    model_reset(cyc);
    @(negedge clk);
    run_op("t6_after", 12'h340, 0, 0, F_RS, 0, 0, P_M, 0, r, il);
    check_eq("t6_discarded", r, 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [1:0] pv;
      pv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : P_M;
      run_op($sformatf("rnd%0d", i), addr_pool[$urandom_range(0, 23)], 1'($urandom),
             1'($urandom), 2'($urandom), $urandom, 5'($urandom), pv, 0, r, il);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
